// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer for one pipeline stage.
// A main register drives the output and a skid register catches the one beat
// that can arrive while the downstream stalls. in_ready comes from a register,
// so there is no combinational path from out_ready back to in_ready.
// Optional feature: define PIPE_SKID_PERF_EN to build the saturating
// stall/bubble performance counters. Without it, both counters are tied to zero.
//
//   state   | meaning
//   --------+--------------------------------------------
//   S_EMPTY | no beat held, output is a zero bubble
//   S_ONE   | one beat in main, shown on out_payload
//   S_FULL  | main plus skid held, upstream is held off
module pipe_skid_stage #(
  parameter int PAYLOAD_W = 70,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PAYLOAD_W-1:0]   main_q, main_d;
  logic [PAYLOAD_W-1:0]   skid_q, skid_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   accept, issue;

  assign accept = in_valid & in_ready_q;
  assign issue  = out_valid_q & out_ready;

  // Next state and payload moves; flush wins over any handshake this cycle.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d = S_ONE;
            main_d  = in_payload;
          end
        end
        S_ONE: begin
          if (accept && issue) begin
            main_d = in_payload;
          end else if (accept) begin
            state_d = S_FULL;
            skid_d  = in_payload;
          end else if (issue) begin
            state_d = S_EMPTY;
            main_d  = '0;
          end
        end
        S_FULL: begin
          // in_ready is low here, so the only move is draining main.
          if (issue) begin
            state_d = S_ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
    in_ready_d  = (state_d != S_FULL);
    out_valid_d = (state_d != S_EMPTY);
  end

  // State, payload and handshake output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_payload = main_q;

`ifdef PIPE_SKID_PERF_EN
  logic [CNT_W-1:0] stall_q, bubble_q;

  // Saturating counters; each cycle is classified by the state before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid_q && !out_ready && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
      if (!out_valid_q && (bubble_q != '1))
        bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage with hand-computed expectations.
// Counter expectations follow the PIPE_SKID_PERF_EN setting of the build.
module tb_pipe_skid_stage;

  localparam int PW = 70;
  localparam int CW = 4;
`ifdef PIPE_SKID_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [PW-1:0] in_payload, out_payload;
  logic [CW-1:0] stall_cnt, bubble_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_skid_stage #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_payload (in_payload),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_payload(out_payload),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] cnt_exp(input int v);
    return PERF ? PW'(v) : '0;
  endfunction

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_payload = '0;
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_payload", out_payload, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_stall", stall_cnt, 0);
    check("rst_bubble", bubble_cnt, 0);

    // Single beat, one-cycle latency.
    in_valid = 1'b1; in_payload = PW'(8'h0A); out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat_valid", out_valid, 1);
    check("lat_payload", out_payload, PW'(8'h0A));
    check("lat_in_ready", in_ready, 1);
    step();
    check("lat_drain_valid", out_valid, 0);
    check("lat_drain_payload", out_payload, 0);

    // Fill to FULL under stall, then drain in order.
    out_ready = 1'b0;
    in_valid = 1'b1; in_payload = PW'(1);
    step();
    check("fill1_in_ready", in_ready, 1);
    in_payload = PW'(2);
    step();
    in_valid = 1'b0;
    check("full_in_ready", in_ready, 0);
    check("full_valid", out_valid, 1);
    check("full_payload", out_payload, PW'(1));
    out_ready = 1'b1;
    step();
    check("drain2_payload", out_payload, PW'(2));
    check("drain2_in_ready", in_ready, 1);
    step();
    check("drain_end_valid", out_valid, 0);
    check("drain_end_payload", out_payload, 0);

    // Flush from FULL with a simultaneous accept attempt and issue.
    out_ready = 1'b0;
    in_valid = 1'b1; in_payload = PW'(1);
    step();
    in_payload = PW'(2);
    step();
    check("pre_flush_in_ready", in_ready, 0);
    flush = 1'b1; out_ready = 1'b1; in_payload = PW'(3);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_payload", out_payload, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("flush_no_beat3", out_valid, 0);
    end

    // Streaming: one beat per cycle, never backs up.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      in_payload = PW'(i);
      step();
      check("stream_payload", out_payload, PW'(i));
      check("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    check("stream_end_valid", out_valid, 0);

    // Counters: one bubble cycle, then a long stall that saturates.
    do_reset();
    in_valid = 1'b1; in_payload = PW'(5); out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("bubble_one", bubble_cnt, cnt_exp(1));
    for (int k = 0; k < 14; k++) step();
    check("stall_14", stall_cnt, cnt_exp(14));
    for (int k = 0; k < 6; k++) step();
    check("stall_sat", stall_cnt, cnt_exp(15));
    check("bubble_hold", bubble_cnt, cnt_exp(1));
    check("stall_hold_payload", out_payload, PW'(5));

    // Reset while FULL, with handshakes and flush active, must win.
    in_valid = 1'b1; in_payload = PW'(6);
    step();
    check("rstfull_in_ready", in_ready, 0);
    rst = 1'b1; flush = 1'b1; in_payload = PW'(7); out_ready = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("rstfull_valid", out_valid, 0);
    check("rstfull_payload", out_payload, 0);
    check("rstfull_in_ready", in_ready, 1);
    check("rstfull_stall", stall_cnt, 0);
    check("rstfull_bubble", bubble_cnt, 0);
    step();
    check("post_rst_bubble", bubble_cnt, cnt_exp(1));
    check("post_rst_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
